// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller.
//   state_t    : controller state encoding (RUN / MD_WAIT)
//   NOP_INSTR  : instruction word the datapath loads into a register on a bubble
package pipeline_stall_controller_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for stall statistics.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high clear
//   inc    : count this cycle
//   count  : current value, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard / stall controller for a five-stage pipeline with a multi-cycle
// mul/div unit in S3.
//
// Optional feature: define STALL_CNT_EN to add the load-use and mul/div
// stall counters (LU_STALL_CNT, MD_STALL_CNT, width CNT_W).
//
// Ports:
//   CLK, RESET                 : clock, synchronous active-high reset
//   REG_ADDR1/2, RS1/2_USED_S2 : S2 source operands and their use flags
//   MEM_READ_S3, REG_W_ADDR_S3 : S3 load flag and destination register
//   MULDIV_S3                  : S3 holds a multi-cycle M-extension op
//   BJ_SIG                     : branch/jump taken, resolved in S3
//   MD_DONE                    : mul/div result valid
//   PC_HOLD, HOLD_P1, HOLD_P2  : freeze PC, S1/S2, S2/S3 registers
//   BUBBLE_P2, BUBBLE_P3       : load NOP into S2/S3, S3/S4 registers
//   FLUSH_P1, FLUSH_P2         : clear S1/S2, S2/S3 registers
//   MD_START, MD_BUSY          : mul/div start pulse, waiting for result
//   LU_STALL_CNT, MD_STALL_CNT : stall counters (STALL_CNT_EN only)
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal flow: load-use stalls, flushes, mul/div launch
// MD_WAIT | mul/div in flight, front of pipe frozen until MD_DONE
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] REG_ADDR1,
  input  logic [4:0] REG_ADDR2,
  input  logic       RS1_USED_S2,
  input  logic       RS2_USED_S2,
  input  logic       MEM_READ_S3,
  input  logic [4:0] REG_W_ADDR_S3,
  input  logic       MULDIV_S3,
  input  logic       BJ_SIG,
  input  logic       MD_DONE,
  output logic       PC_HOLD,
  output logic       HOLD_P1,
  output logic       HOLD_P2,
  output logic       BUBBLE_P2,
  output logic       BUBBLE_P3,
  output logic       FLUSH_P1,
  output logic       FLUSH_P2,
  output logic       MD_START,
  output logic       MD_BUSY
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] LU_STALL_CNT,
  output logic [CNT_W-1:0] MD_STALL_CNT
`endif
);

  state_t state;

  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic in_run;
  logic in_wait;
  logic flush;
  logic md_go;
  logic lu_stall;
  logic md_hold;

  assign rs1_hit  = RS1_USED_S2 && (REG_ADDR1 == REG_W_ADDR_S3);
  assign rs2_hit  = RS2_USED_S2 && (REG_ADDR2 == REG_W_ADDR_S3);
  // x0 is never really written, so a load to x0 can not create a hazard.
  assign load_use = MEM_READ_S3 && (REG_W_ADDR_S3 != 5'd0) && (rs1_hit || rs2_hit);

  // Everything is gated by RESET so the outputs are quiet while it is held.
  assign in_run  = (state == RUN) && !RESET;
  assign in_wait = (state == MD_WAIT) && !RESET;

  // A taken branch wins over everything else: its flush clears the very
  // registers a stall would freeze, and S3 can not be a mul/div op then.
  assign flush    = in_run && BJ_SIG;
  assign md_go    = in_run && MULDIV_S3 && !BJ_SIG;
  // A mul/div launch already freezes S1..S3, so it absorbs a load-use stall.
  assign lu_stall = in_run && load_use && !BJ_SIG && !MULDIV_S3;
  // On MD_DONE the holds drop in the same cycle so the result moves to S4.
  assign md_hold  = md_go || (in_wait && !MD_DONE);

  always_comb begin
    PC_HOLD   = lu_stall || md_hold;
    HOLD_P1   = lu_stall || md_hold;
    HOLD_P2   = md_hold;
    BUBBLE_P2 = lu_stall;
    BUBBLE_P3 = md_hold;
    FLUSH_P1  = flush;
    FLUSH_P2  = flush;
    MD_START  = md_go;
    MD_BUSY   = in_wait;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (MULDIV_S3 && !BJ_SIG) state <= MD_WAIT;
        MD_WAIT: if (MD_DONE) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef STALL_CNT_EN
  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk   (CLK),
    .reset (RESET),
    .inc   (lu_stall),
    .count (LU_STALL_CNT)
  );

  sat_counter #(.W(CNT_W)) u_md_cnt (
    .clk   (CLK),
    .reset (RESET),
    .inc   (in_wait),
    .count (MD_STALL_CNT)
  );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller. Output vector order used in
// expected values: {PC_HOLD, HOLD_P1, HOLD_P2, BUBBLE_P2, BUBBLE_P3,
//                   FLUSH_P1, FLUSH_P2, MD_START, MD_BUSY}
module tb_pipeline_stall_controller;

  localparam int CNT_W = 16;

  localparam logic [8:0] O_NONE  = 9'b000000000;
  localparam logic [8:0] O_LU    = 9'b110100000;
  localparam logic [8:0] O_FLUSH = 9'b000001100;
  localparam logic [8:0] O_MDGO  = 9'b111010010;
  localparam logic [8:0] O_MDW   = 9'b111010001;
  localparam logic [8:0] O_MDDN  = 9'b000000001;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] REG_ADDR1, REG_ADDR2, REG_W_ADDR_S3;
  logic       RS1_USED_S2, RS2_USED_S2, MEM_READ_S3, MULDIV_S3, BJ_SIG, MD_DONE;
  logic       PC_HOLD, HOLD_P1, HOLD_P2, BUBBLE_P2, BUBBLE_P3;
  logic       FLUSH_P1, FLUSH_P2, MD_START, MD_BUSY;
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] LU_STALL_CNT, MD_STALL_CNT;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  pipeline_stall_controller #(.CNT_W(CNT_W)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .REG_ADDR1     (REG_ADDR1),
    .REG_ADDR2     (REG_ADDR2),
    .RS1_USED_S2   (RS1_USED_S2),
    .RS2_USED_S2   (RS2_USED_S2),
    .MEM_READ_S3   (MEM_READ_S3),
    .REG_W_ADDR_S3 (REG_W_ADDR_S3),
    .MULDIV_S3     (MULDIV_S3),
    .BJ_SIG        (BJ_SIG),
    .MD_DONE       (MD_DONE),
    .PC_HOLD       (PC_HOLD),
    .HOLD_P1       (HOLD_P1),
    .HOLD_P2       (HOLD_P2),
    .BUBBLE_P2     (BUBBLE_P2),
    .BUBBLE_P3     (BUBBLE_P3),
    .FLUSH_P1      (FLUSH_P1),
    .FLUSH_P2      (FLUSH_P2),
    .MD_START      (MD_START),
    .MD_BUSY       (MD_BUSY)
`ifdef STALL_CNT_EN
    ,
    .LU_STALL_CNT  (LU_STALL_CNT),
    .MD_STALL_CNT  (MD_STALL_CNT)
`endif
  );

  function automatic logic [8:0] outs();
    return {PC_HOLD, HOLD_P1, HOLD_P2, BUBBLE_P2, BUBBLE_P3,
            FLUSH_P1, FLUSH_P2, MD_START, MD_BUSY};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Sample combinational outputs mid-cycle, away from the active edge.
  task automatic chk_outs(input string tag, input logic [8:0] exp);
    @(negedge CLK);
    check(tag, {23'd0, outs()}, {23'd0, exp});
  endtask

  task automatic idle_inputs();
    REG_ADDR1 = 5'd0; REG_ADDR2 = 5'd0; REG_W_ADDR_S3 = 5'd0;
    RS1_USED_S2 = 1'b0; RS2_USED_S2 = 1'b0; MEM_READ_S3 = 1'b0;
    MULDIV_S3 = 1'b0; BJ_SIG = 1'b0; MD_DONE = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] a1, input logic u1,
                          input logic [4:0] a2, input logic u2);
    MEM_READ_S3 = 1'b1; REG_W_ADDR_S3 = rd;
    REG_ADDR1 = a1; RS1_USED_S2 = u1;
    REG_ADDR2 = a2; RS2_USED_S2 = u2;
  endtask

  initial begin
    idle_inputs();
    RESET = 1'b1;
    // Hazard and mul/div request present during reset must stay invisible.
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    MULDIV_S3 = 1'b1;
    tick();
    chk_outs("reset_quiet", O_NONE);
    tick();
`ifdef STALL_CNT_EN
    check("reset_lu_cnt", LU_STALL_CNT, 0);
    check("reset_md_cnt", MD_STALL_CNT, 0);
`endif
    RESET = 1'b0;
    idle_inputs();
    chk_outs("idle_after_reset", O_NONE);

    // Load x5, S2 reads rs1=x5: one stall cycle, then quiet.
    tick(); set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    chk_outs("lu_rs1", O_LU);
    tick(); idle_inputs();
    chk_outs("lu_rs1_next", O_NONE);

    // rs2 match with use flag, then the same match without the use flag.
    tick(); set_load(5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
    chk_outs("lu_rs2", O_LU);
    tick(); set_load(5'd9, 5'd3, 1'b1, 5'd9, 1'b0);
    chk_outs("lu_rs2_unused", O_NONE);

    // Load to x0 read as x0: no hazard.
    tick(); set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    chk_outs("lu_x0", O_NONE);

    // Taken branch with a would-be hazard: flush only.
    tick(); set_load(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); BJ_SIG = 1'b1;
    chk_outs("bj_flush", O_FLUSH);

    // MD_DONE in RUN is ignored.
    tick(); idle_inputs(); MD_DONE = 1'b1;
    chk_outs("md_done_in_run", O_NONE);

    // Mul/div with result 5 cycles after start.
    tick(); idle_inputs(); MULDIV_S3 = 1'b1;
    chk_outs("md5_start", O_MDGO);
    for (int i = 1; i <= 4; i++) begin
      tick();
      // Hazard and branch inputs must be ignored while waiting.
      if (i == 2) begin
        set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        BJ_SIG = 1'b1;
      end else begin
        MEM_READ_S3 = 1'b0; BJ_SIG = 1'b0;
      end
      chk_outs($sformatf("md5_wait%0d", i), O_MDW);
    end
    tick(); MD_DONE = 1'b1;
    chk_outs("md5_done", O_MDDN);
    tick(); idle_inputs();
    chk_outs("md5_back_run", O_NONE);
`ifdef STALL_CNT_EN
    check("md5_md_cnt", MD_STALL_CNT, 5);
    check("md5_lu_cnt", LU_STALL_CNT, 2);
`endif

    // Two back-to-back divides, latency 1: starts two cycles apart.
    tick(); MULDIV_S3 = 1'b1;
    chk_outs("b2b_start1", O_MDGO);
    tick(); MD_DONE = 1'b1;
    chk_outs("b2b_done1", O_MDDN);
    tick(); MD_DONE = 1'b0;
    chk_outs("b2b_start2", O_MDGO);
    tick(); MD_DONE = 1'b1;
    chk_outs("b2b_done2", O_MDDN);
    tick(); idle_inputs();
    chk_outs("b2b_idle", O_NONE);
`ifdef STALL_CNT_EN
    check("b2b_md_cnt", MD_STALL_CNT, 7);
`endif

    // Reset in the third MD_WAIT cycle abandons the operation.
    tick(); MULDIV_S3 = 1'b1;
    chk_outs("rst_md_start", O_MDGO);
    tick(); chk_outs("rst_md_wait1", O_MDW);
    tick(); chk_outs("rst_md_wait2", O_MDW);
    tick(); RESET = 1'b1;
    chk_outs("rst_md_in_reset", O_NONE);
    tick(); RESET = 1'b0; idle_inputs();
    chk_outs("rst_md_after", O_NONE);
`ifdef STALL_CNT_EN
    check("rst_md_lu_cnt", LU_STALL_CNT, 0);
    check("rst_md_md_cnt", MD_STALL_CNT, 0);
`endif
    // Back in RUN: a load-use hazard stalls again.
    tick(); set_load(5'd12, 5'd0, 1'b0, 5'd12, 1'b1);
    chk_outs("rst_md_run_lu", O_LU);
    tick(); idle_inputs();
    chk_outs("final_idle", O_NONE);
`ifdef STALL_CNT_EN
    check("final_lu_cnt", LU_STALL_CNT, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the stall-counter width in bits (used only when STALL_CNT_EN is defined).
REQ-002 SHALL have ports, one per line:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REG_ADDR1, REG_ADDR2  in  5 each  S2 source register addresses.
- RS1_USED_S2, RS2_USED_S2  in  1 each  S2 instruction reads rs1/rs2.
- MEM_READ_S3  in  1  S3 instruction is a load.
- REG_W_ADDR_S3  in  5  S3 destination register.
- MULDIV_S3  in  1  S3 holds a multi-cycle M-extension op.
- BJ_SIG  in  1  branch/jump taken, resolved in S3.
- MD_DONE  in  1  mul/div unit result valid.
- PC_HOLD, HOLD_P1, HOLD_P2  out  1 each  freeze PC, S1/S2 register, S2/S3 register.
- BUBBLE_P2, BUBBLE_P3  out  1 each  load a NOP into the S2/S3 or S3/S4 register.
- FLUSH_P1, FLUSH_P2  out  1 each  clear the S1/S2 and S2/S3 registers.
- MD_START  out  1  one-cycle start pulse to the mul/div unit.
- MD_BUSY  out  1  FSM is in MD_WAIT.
- LU_STALL_CNT, MD_STALL_CNT  out  CNT_W each  stall counters (present only with STALL_CNT_EN).

Function
REQ-003 SHALL implement an FSM with two states, RUN and MD_WAIT.
REQ-004 In RUN, a load-use hazard SHALL be detected when all of the following hold:
- MEM_READ_S3=1.
- REG_W_ADDR_S3 is not 0.
- REG_W_ADDR_S3 matches REG_ADDR1 with RS1_USED_S2=1, or matches REG_ADDR2 with RS2_USED_S2=1.
REQ-005 On a load-use hazard in RUN, PC_HOLD, HOLD_P1 and BUBBLE_P2 SHALL assert combinationally for exactly that cycle; the state SHALL remain RUN.
REQ-006 In RUN, BJ_SIG=1 SHALL assert FLUSH_P1 and FLUSH_P2 for that cycle and suppress the load-use stall outputs.
REQ-007 In RUN with MULDIV_S3=1, the block SHALL perform all of the following:
- Pulse MD_START for that cycle only.
- Assert PC_HOLD, HOLD_P1, HOLD_P2 and BUBBLE_P3.
- Enter MD_WAIT at the next edge.
REQ-008 In RUN, MD_DONE SHALL be ignored; minimum mul/div latency is 1 cycle after MD_START.
REQ-009 In MD_WAIT, PC_HOLD, HOLD_P1, HOLD_P2, BUBBLE_P3 and MD_BUSY SHALL stay asserted while MD_DONE=0; load-use detection and MD_START SHALL be suppressed.
REQ-010 In MD_WAIT with MD_DONE=1, all holds and BUBBLE_P3 SHALL deassert in that same cycle, so the result advances into S4; the state SHALL return to RUN at the next edge.
REQ-011 A new MULDIV_S3 in the first RUN cycle after MD_WAIT SHALL start a fresh operation; back-to-back ops carry no extra penalty.
REQ-012 BJ_SIG SHALL be ignored in MD_WAIT, since S3 holds a non-branch op.
REQ-013 Hold and flush on the same register SHALL never assert together; flush has priority.

Reset
REQ-014 With RESET=1 at a rising edge, the state SHALL become RUN and, with STALL_CNT_EN, both counters SHALL clear to 0.
REQ-015 While RESET=1, every control output SHALL be 0.
REQ-016 RESET asserted during MD_WAIT SHALL abandon the operation without issuing MD_START; the mul/div unit shares RESET.

Configuration
REQ-017 With STALL_CNT_EN defined:
- LU_STALL_CNT SHALL increment on every cycle with a REQ-005 stall.
- MD_STALL_CNT SHALL increment on every cycle with MD_BUSY=1.
- Both counters SHALL saturate at all-ones.
REQ-018 Without STALL_CNT_EN, the counter ports and logic SHALL be absent.

Structure
REQ-019 A shared package SHALL hold the state encoding (RUN=1'b0, MD_WAIT=1'b1) and the NOP-bubble constant.
REQ-020 The saturating counter SHALL be a sub-module sat_counter, instantiated twice under STALL_CNT_EN.

Verification
REQ-021 The bench SHALL cover:
- Load x5 in S3, S2 reads rs1=x5 (RS1_USED_S2=1) -> one cycle with PC_HOLD=HOLD_P1=BUBBLE_P2=1; next cycle all 0.
- Load to x0 with REG_ADDR1=0 -> no stall.
- Load x7 with BJ_SIG=1 and S2 reading x7 -> FLUSH_P1=FLUSH_P2=1, PC_HOLD=0.
- MULDIV_S3=1, MD_DONE 5 cycles after start -> MD_START high for 1 cycle; holds high 5 cycles; RUN on cycle 6; MD_STALL_CNT=5.
- Two back-to-back DIVs with MD_DONE latency 1 -> two MD_START pulses 2 cycles apart.
- RESET in 3rd MD_WAIT cycle -> next cycle all outputs 0, state RUN, counters 0.
